// File: rtl/fetch_unit.sv
// Instruction fetch: reads 16-byte lines as 4-beat bursts into a line buffer and
// streams one instruction per cycle to decode, with stall, redirect and range check.
module fetch_unit #(
   parameter logic [31:0] START_ADDR = 32'h0,
   parameter logic [31:0] MEM_BYTES  = 32'd1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_error,
   output logic        mem_enable,
   output logic        mem_rd_wr,
   output logic [1:0]  mem_access_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   input  logic        mem_busy
);
   typedef enum logic [1:0] {S_REQ, S_BURST, S_DELIVER, S_ERROR} state_t;

   state_t         state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [31:0]    redir_pc_q, redir_pc_d;
   logic           redir_pend_q, redir_pend_d;
   logic [1:0]     beat_q, beat_d;
   logic [3:0][31:0] line_q;

   logic [31:0]    redir_tgt;
   logic           pc_oor;
   logic           req_fire;
   logic           unused_addr_lsb;

   assign redir_tgt       = {redirect_addr[31:2], 2'b00};
   assign unused_addr_lsb = ^redirect_addr[1:0];
   assign pc_oor          = (pc_q >= MEM_BYTES);
   // Request is a decode of registered state; busy/reset only suppress it.
   assign req_fire        = (state_q == S_REQ) && !pc_oor && !mem_busy && !reset;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      beat_d       = beat_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      unique case (state_q)
         S_REQ: begin
            if (req_fire) begin
               state_d = S_BURST;
               beat_d  = 2'd0;
               if (redirect) begin
                  redir_pend_d = 1'b1;
                  redir_pc_d   = redir_tgt;
               end
            end else if (redirect) begin
               pc_d = redir_tgt;
            end else if (pc_oor) begin
               state_d = S_ERROR;
            end
         end
         S_BURST: begin
            beat_d = beat_q + 2'd1;
            if (redirect) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redir_tgt;
            end
            // A redirect arriving on the last beat is the newest target.
            if (beat_q == 2'd3) begin
               if (redirect || redir_pend_q) begin
                  pc_d         = redirect ? redir_tgt : redir_pc_q;
                  redir_pend_d = 1'b0;
                  state_d      = S_REQ;
               end else begin
                  state_d = S_DELIVER;
               end
            end
         end
         S_DELIVER: begin
            if (redirect) begin
               pc_d    = redir_tgt;
               state_d = S_REQ;
            end else if (!stall) begin
               pc_d = pc_q + 32'd4;
               if (pc_q[3:2] == 2'd3) state_d = S_REQ;
            end
         end
         S_ERROR: begin
            if (redirect) begin
               pc_d    = redir_tgt;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_REQ;
         pc_q         <= {START_ADDR[31:2], 2'b00};
         beat_q       <= 2'd0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         beat_q       <= beat_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && state_q == S_BURST) line_q[beat_q] <= mem_data_out;
   end

   assign instr_valid     = (state_q == S_DELIVER);
   assign instr           = instr_valid ? line_q[pc_q[3:2]] : 32'h0;
   assign instr_pc        = instr_valid ? pc_q : 32'h0;
   assign fetch_error     = (state_q == S_ERROR);
   assign mem_enable      = req_fire;
   assign mem_rd_wr       = req_fire;
   assign mem_access_size = req_fire ? 2'd1 : 2'd0;
   assign mem_addr        = req_fire ? {pc_q[31:4], 4'h0} : 32'h0;
   assign mem_data_in     = 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: burst memory responder, behavioural fetch model feeding a
// scoreboard queue, directed scenarios plus randomized stall/redirect/busy/reset.
module tb_fetch_unit;
   localparam logic [31:0] START = 32'h0;
   localparam logic [31:0] MEMB  = 32'd1048576;

   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        instr_valid, fetch_error, mem_enable, mem_rd_wr, mem_busy;
   logic [31:0] instr, instr_pc, mem_addr, mem_data_in;
   logic [31:0] mem_data_out = 32'h0;
   logic [1:0]  mem_access_size;
   logic        busy_r = 1'b0, bursting = 1'b0;

   assign mem_busy = busy_r | bursting;
   always #5 clk = ~clk;

   fetch_unit #(.START_ADDR(START), .MEM_BYTES(MEMB)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_addr(redirect_addr), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .fetch_error(fetch_error), .mem_enable(mem_enable),
      .mem_rd_wr(mem_rd_wr), .mem_access_size(mem_access_size), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_busy(mem_busy));

   int total = 0, bad = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory contents and burst responder ----------------
   logic [31:0] mem [logic [31:0]];
   function automatic logic [31:0] rdw(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (mem.exists(w)) return mem[w];
      return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   int bleft = 0;
   logic [31:0] baddr = 32'h0;
   always @(posedge clk) begin
      if (mem_enable && mem_rd_wr && mem_access_size == 2'd1) begin
         mem_data_out <= rdw(mem_addr);
         baddr <= mem_addr + 32'd4;
         bleft <= 3;
         bursting <= 1'b1;
      end else if (bleft > 0) begin
         mem_data_out <= rdw(baddr);
         baddr <= baddr + 32'd4;
         bleft <= bleft - 1;
      end else begin
         bursting <= 1'b0;
         mem_data_out <= 32'hBAD00000 ^ 32'(cyc);
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
      end
   endtask

   // ---------------- behavioural model -> scoreboard ----------------
   typedef struct packed {
      logic v; logic [31:0] ins; logic [31:0] pc; logic fe; logic en; logic rw;
      logic [1:0] asz; logic [31:0] addr; logic [31:0] din;
   } exp_t;
   exp_t expq[$];

   logic [31:0] m_pc = 32'h0, m_rpc = 32'h0;
   logic        m_have = 1'b0, m_err = 1'b0, m_pend = 1'b0, m_req = 1'b0;
   int          m_left = -1;   // beats still to arrive for the outstanding line

   task automatic model_edge();
      logic [31:0] tgt;
      tgt = {redirect_addr[31:2], 2'b00};
      if (reset) begin
         m_pc = START & ~32'd3; m_left = -1; m_have = 0; m_err = 0; m_pend = 0;
      end else if (m_err) begin
         if (redirect) begin m_pc = tgt; m_err = 0; end
      end else if (m_have) begin
         if (redirect) begin m_pc = tgt; m_have = 0; end
         else if (!stall) begin
            if (m_pc[3:2] == 2'd3) m_have = 0;
            m_pc = m_pc + 32'd4;
         end
      end else if (m_left > 0) begin
         if (redirect) begin m_pend = 1; m_rpc = tgt; end
         m_left--;
         if (m_left == 0) begin
            m_left = -1;
            if (m_pend) begin m_pc = m_rpc; m_pend = 0; end
            else m_have = 1;
         end
      end else if (m_req) begin
         m_left = 4;
         if (redirect) begin m_pend = 1; m_rpc = tgt; end
      end else if (redirect) begin
         m_pc = tgt;
      end else if (m_pc >= MEMB) begin
         m_err = 1;
      end
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk);
      model_edge();
      #2;
      m_req = !reset && !m_err && !m_have && (m_left < 0) && !mem_busy && (m_pc < MEMB);
      e = '0;
      if (m_have) begin e.v = 1; e.ins = rdw(m_pc); e.pc = m_pc; end
      e.fe = m_err;
      if (m_req) begin e.en = 1; e.rw = 1; e.asz = 2'd1; e.addr = m_pc & ~32'd15; end
      expq.push_back(e);
   end

   // ---------------- monitor + event logs ----------------
   typedef struct { int cyc; logic [31:0] addr; } req_t;
   typedef struct { int cyc; logic [31:0] pc; logic [31:0] ins; } dl_t;
   req_t req_log[$];
   dl_t  dl_log[$];

   initial forever begin
      exp_t a, e;
      @(negedge clk);
      a = {instr_valid, instr, instr_pc, fetch_error, mem_enable, mem_rd_wr,
           mem_access_size, mem_addr, mem_data_in};
      total++;
      if (expq.size() == 0) begin
         bad++;
         $display("FAIL scoreboard empty at cycle %0d", cyc);
      end else begin
         e = expq.pop_front();
         if (a !== e) begin
            bad++;
            $display("FAIL outputs cycle %0d: got %h want %h", cyc, a, e);
         end
      end
      if (instr_valid) dl_log.push_back('{cyc, instr_pc, instr});
      if (mem_enable)  req_log.push_back('{cyc, mem_addr});
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      req_log.delete(); dl_log.delete();
   endtask

   // kind 0: valid with given pc, 1: any valid, 2: memory request
   task automatic wait_for(input int kind, input logic [31:0] pc_v);
      int n;
      n = 0;
      while (!(kind == 0 ? (instr_valid && instr_pc == pc_v) :
               kind == 1 ? instr_valid : mem_enable)) begin
         step();
         n++;
         if (n > 200) begin
            total++; bad++;
            $display("FAIL wait kind %0d: no event after %0d cycles", kind, n);
            return;
         end
      end
   endtask

   logic [31:0] p1w [4];
   int t0;

   initial begin
      p1w = '{32'd234, 32'd1537628013, 32'd537628013, 32'd2537628013};
      for (int i = 0; i < 4; i++) mem[32'(4 * i)] = p1w[i];
      mem[32'd1048572] = 32'd10448573;

      // reset and first line
      reset = 1'b1;
      repeat (3) step();
      chk("reset outputs", {instr_valid, fetch_error, mem_enable, instr_pc}, 0);
      reset = 1'b0; t0 = cyc; clr();
      repeat (12) step();
      chk("p1 req count", req_log.size(), 2);
      chk("p1 dl count", dl_log.size(), 4);
      if (req_log.size() == 2) begin
         chk("p1 req0 cyc", req_log[0].cyc - t0, 0);
         chk("p1 req0 addr", req_log[0].addr, 0);
         chk("p1 req1 cyc", req_log[1].cyc - t0, 9);
         chk("p1 req1 addr", req_log[1].addr, 16);
      end
      for (int i = 0; i < dl_log.size() && i < 4; i++) begin
         chk("p1 dl cyc", dl_log[i].cyc - t0, 5 + i);
         chk("p1 dl pc", dl_log[i].pc, 4 * i);
         chk("p1 dl instr", dl_log[i].ins, p1w[i]);
      end

      // stall hold at pc 4
      reset = 1'b1; step(); reset = 1'b0;
      wait_for(0, 32'd4);
      t0 = cyc; stall = 1'b1; clr();
      repeat (3) step();
      stall = 1'b0;
      repeat (4) step();
      chk("p2 dl count", dl_log.size(), 6);
      chk("p2 req count", req_log.size(), 1);
      if (dl_log.size() >= 5) begin
         chk("p2 held instr", dl_log[2].ins, 32'd1537628013);
         chk("p2 held pc", dl_log[3].pc, 4);
         chk("p2 next pc", dl_log[4].pc, 8);
         chk("p2 next cyc", dl_log[4].cyc - t0, 4);
      end

      // redirect in DELIVER
      wait_for(1, 32'h0);
      t0 = cyc; redirect = 1'b1; redirect_addr = 32'h27;
      step(); redirect = 1'b0; clr();
      repeat (8) step();
      if (req_log.size() > 0) begin
         chk("p3 req cyc", req_log[0].cyc - t0, 1);
         chk("p3 req addr", req_log[0].addr, 32'h20);
      end else chk("p3 req count", req_log.size(), 1);
      if (dl_log.size() > 0) begin
         chk("p3 first pc", dl_log[0].pc, 32'h24);
         chk("p3 first cyc", dl_log[0].cyc - t0, 6);
         chk("p3 first instr", dl_log[0].ins, rdw(32'h24));
      end else chk("p3 dl count", dl_log.size(), 1);

      // redirect during burst, after beat 1
      wait_for(2, 32'h0);
      t0 = cyc;
      repeat (3) step();
      redirect = 1'b1; redirect_addr = 32'h40;
      step(); redirect = 1'b0; clr();
      repeat (7) step();
      chk("p4 req count", req_log.size(), 1);
      chk("p4 dl count", dl_log.size(), 1);
      if (req_log.size() > 0) begin
         chk("p4 req cyc", req_log[0].cyc - t0, 5);
         chk("p4 req addr", req_log[0].addr, 32'h40);
      end
      if (dl_log.size() > 0) begin
         chk("p4 dl cyc", dl_log[0].cyc - t0, 10);
         chk("p4 dl pc", dl_log[0].pc, 32'h40);
      end

      // out-of-range pc and recovery
      wait_for(1, 32'h0);
      redirect = 1'b1; redirect_addr = MEMB;
      step(); redirect = 1'b0; clr();
      repeat (6) step();
      chk("p5 fetch_error", fetch_error, 1);
      chk("p5 no req", req_log.size(), 0);
      redirect = 1'b1; redirect_addr = 32'd1048572;
      step(); redirect = 1'b0;
      chk("p5 error cleared", fetch_error, 0);
      t0 = cyc; clr();
      repeat (8) step();
      if (req_log.size() > 0) begin
         chk("p5 req addr", req_log[0].addr, 32'd1048560);
         chk("p5 req cyc", req_log[0].cyc - t0, 0);
      end else chk("p5 req count", req_log.size(), 1);
      if (dl_log.size() > 0) begin
         chk("p5 dl pc", dl_log[0].pc, 32'd1048572);
         chk("p5 dl instr", dl_log[0].ins, 32'd10448573);
      end else chk("p5 dl count", dl_log.size(), 1);

      // reset mid-burst, then busy for two cycles
      redirect = 1'b1; redirect_addr = 32'h100;
      step(); redirect = 1'b0;
      wait_for(2, 32'h0);
      t0 = cyc;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0; busy_r = 1'b1;
      chk("p6 ctl zero", {instr_valid, fetch_error, mem_enable, mem_rd_wr, mem_access_size}, 0);
      chk("p6 data zero", {instr, instr_pc}, 0);
      chk("p6 addr zero", mem_addr, 0);
      clr();
      step();
      step(); busy_r = 1'b0;
      repeat (3) step();
      if (req_log.size() > 0) begin
         chk("p6 req cyc", req_log[0].cyc - t0, 6);
         chk("p6 req addr", req_log[0].addr, START & ~32'd15);
      end else chk("p6 req count", req_log.size(), 1);

      // randomized traffic, checked by the scoreboard every cycle
      for (int i = 0; i < 3000; i++) begin
         stall    = ($urandom_range(0, 99) < 30);
         busy_r   = ($urandom_range(0, 99) < 15);
         reset    = ($urandom_range(0, 199) < 2);
         redirect = ($urandom_range(0, 99) < 6);
         case ($urandom_range(0, 3))
            0, 1: redirect_addr = $urandom_range(0, 32'h3FF);
            2:    redirect_addr = MEMB - $urandom_range(0, 40);
            default: redirect_addr = $urandom();
         endcase
         step();
      end
      stall = 1'b0; busy_r = 1'b0; reset = 1'b0; redirect = 1'b0;
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator for the `memory` block: it drives the memory's request port and streams 32-bit instructions to the decode stage. It reads whole 16-byte lines with 4-word burst reads (`access_size` = 1), buffers each line, and hands out one instruction per cycle. It supports decode back-pressure (`stall`), branch redirect and out-of-range PC detection. It never writes memory.

## Interface
- `START_ADDR`, default 32'h0: PC loaded on reset. Low 2 bits are ignored.
- `MEM_BYTES`, default 1048576: memory size. Any PC ≥ `MEM_BYTES` is out of range.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode cannot accept this cycle.
- `redirect`  in  1  load a new PC (branch/jump).
- `redirect_addr`  in  32  new PC. Bits [1:0] are dropped.
- `instr_valid`  out  1  `instr`/`instr_pc` are valid.
- `instr`  out  32  instruction word.
- `instr_pc`  out  32  byte address of `instr`.
- `fetch_error`  out  1  current PC is out of range.
- `mem_enable`  out  1  to memory `enable`.
- `mem_rd_wr`  out  1  to memory `rd_wr`; 1 = read.
- `mem_access_size`  out  2  to memory `access_size`. Always 2'd1 when `mem_enable`=1, else 0.
- `mem_addr`  out  32  to memory `addr`. 16-byte aligned.
- `mem_data_in`  out  32  to memory `data_in`. Constant 0.
- `mem_data_out`  in  32  from memory `data_out`.
- `mem_busy`  in  1  from memory `busy`.

## Operation
- **Registers**
  - `pc` [31:0].
  - Line buffer `buf[0..3]`.
  - `beat` [1:0].
  - `redir_pend` flag and `redir_pc` [31:0].
  - State ∈ {REQ, BURST, DELIVER, ERROR}.
- **Reset**
  - `pc`=START_ADDR & ~3, state=REQ, `beat`=0, `redir_pend`=0.
  - All outputs 0.
  - `buf` is not cleared.
- **REQ**
  - If `pc` ≥ MEM_BYTES: go to ERROR.
  - Else if `mem_busy`=1: issue nothing and wait.
  - Else, for exactly one cycle: `mem_enable`=1, `mem_rd_wr`=1, `mem_access_size`=1, `mem_addr`={pc[31:4],4'b0}. Next state BURST, `beat`=0.
- **BURST**
  - `mem_enable`=0.
  - Each edge: `buf[beat]` ← `mem_data_out`, `beat`++.
  - After the edge capturing beat 3:
    - if `redir_pend`: `pc` ← `redir_pc`, clear `redir_pend`, go to REQ (buffer discarded);
    - else go to DELIVER.
- **DELIVER**
  - Outputs: `instr_valid`=1, `instr`=`buf[pc[3:2]]`, `instr_pc`=`pc`.
  - If `redirect`: `pc` ← `redirect_addr` & ~3, go to REQ. Any undelivered buffer words are dropped.
  - Else if !`stall` and `pc[3:2]`=3: `pc` += 4, go to REQ.
  - Else if !`stall`: `pc` += 4, stay in DELIVER.
  - Else (stall): hold all outputs.
- **Redirect in REQ (request cycle) or BURST**
  - The burst cannot be aborted.
  - Latch `redir_pc` and set `redir_pend`. A later redirect overwrites `redir_pc`.
  - `instr_valid` stays 0 until the new line is delivered.
- **Redirect in REQ while waiting on `mem_busy`**: load `pc` directly; no burst has been issued.
- **ERROR**
  - `fetch_error`=1, `instr_valid`=0, no memory requests.
  - Only `redirect` (load `pc`, go to REQ) or `reset` exits.
  - `fetch_error` clears on the exit edge.
- **Simultaneous events**
  - `reset` beats `redirect`, which beats `stall`.
  - `redirect` and `stall` both high: the redirect is taken.
- **PC wrap**: PC increment wraps modulo 2^32, then is caught by the range check.

## Timing
- **Memory contract**
  - The request is sampled at edge T.
  - Beat k (0..3) is valid in the cycle after edge T+k and is captured at edge T+1+k.
  - `mem_busy` may be high during the burst; the unit counts beats itself.
- **Latency**: from the edge that leaves reset or takes a redirect (state becomes REQ) to `instr_valid`=1 is 5 cycles when `mem_busy`=0.
- **Line rollover**
  - A line delivers 4 instructions on 4 consecutive unstalled cycles.
  - This is followed by a 5-cycle bubble (no prefetch).
- **Outputs**: all outputs are registered, or decoded from registered state only. There is no combinational path from `stall`/`redirect` to the `mem_*` outputs.

## Test plan
1. **Reset and first line.** Setup: START_ADDR=0; memory words 0/4/8/12 = 234 / 1537628013 / 537628013 / 2537628013; `stall`=0; release `reset`.
   - One request: addr 0, `access_size` 1, `rd_wr` 1.
   - 5 cycles later, on consecutive cycles: `instr` 234, 1537628013, 537628013, 2537628013 with `instr_pc` 0, 4, 8, 12.
   - Then a request at addr 16.
2. **Stall hold.** Hold `stall` for 3 cycles while `instr_pc`=4.
   - `instr`=1537628013 and `instr_pc`=4 held; `mem_enable`=0.
   - On release, `instr_pc`=8 the next cycle.
3. **Redirect in DELIVER.** `redirect` to 0x27.
   - Next cycle: request at addr 0x20.
   - First delivered `instr_pc`=0x24. The word at 0x20 is never presented.
4. **Redirect during BURST.** `redirect` to 0x40 after beat 1.
   - Remaining 2 beats are absorbed with `instr_valid`=0.
   - Request at 0x40 in the cycle after beat 3. No second request while `mem_busy`=1.
5. **Out-of-range PC.** `redirect` to 1048576.
   - `fetch_error`=1, `mem_enable` never asserts.
   - Then `redirect` to 1048572 (word 10448573 preloaded):
     - `fetch_error`=0;
     - request at addr 1048560;
     - delivers `instr_pc`=1048572, `instr`=10448573.
6. **Reset mid-burst.** Assert `reset` during beat 2.
   - Next cycle: all outputs 0.
   - After release, with `mem_busy`=1 for 2 more cycles: the request at START_ADDR issues only once `mem_busy`=0.
